// File: rtl/dr_alm_pkg.sv
// Shared widths, stage payload structs and the t clamp for the pipelined DR-ALM.
// Struct widths follow the package configuration; the top's parameters default to it.
package dr_alm_pkg;
  localparam int DR_DWIDTH = 16;
  localparam int DR_T_MAX  = 8;
  localparam int DR_TAG_W  = 4;

  localparam int K_W = $clog2(DR_DWIDTH);
  localparam int T_W = $clog2(DR_T_MAX + 1);
  localparam int P_W = 2 * DR_DWIDTH;

  typedef struct packed {
    logic                sign;
    logic                zero;
    logic [K_W-1:0]      ka;
    logic [K_W-1:0]      kb;
    logic [DR_T_MAX-1:0] xa;
    logic [DR_T_MAX-1:0] xb;
    logic [T_W-1:0]      t;
    logic [DR_TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic                sign;
    logic                zero;
    logic [K_W:0]        k;
    logic [DR_T_MAX:0]   s;
    logic [T_W-1:0]      t;
    logic [DR_TAG_W-1:0] tag;
  } s2_t;

  function automatic logic [T_W-1:0] clamp_t(input logic [T_W-1:0] t);
    if (t < T_W'(2))        return T_W'(2);
    if (t > T_W'(DR_T_MAX)) return T_W'(DR_T_MAX);
    return t;
  endfunction
endpackage

// File: rtl/dr_alm_trunc.sv
// One operand of stage 1: exact magnitude, leading-one position, normalise,
// then keep t-1 bits below the leading one with a trailing 1 appended.
module dr_alm_trunc #(
  parameter  int DWIDTH = 16,
  parameter  int T_MAX  = 8,
  localparam int K_W    = $clog2(DWIDTH),
  localparam int T_W    = $clog2(T_MAX + 1)
) (
  input  logic [DWIDTH-1:0] i_v,
  input  logic [T_W-1:0]    i_t,
  output logic [K_W-1:0]    o_k,
  output logic [T_MAX-1:0]  o_x,
  output logic              o_zero
);
  logic [DWIDTH-1:0] w_abs, w_norm, w_frac, w_mask;

  // Unsigned negate keeps -2^(DWIDTH-1) as 2^(DWIDTH-1).
  assign w_abs = i_v[DWIDTH-1] ? -i_v : i_v;

  always_comb begin
    o_k = '0;
    for (int i = 0; i < DWIDTH; i++)
      if (w_abs[i]) o_k = K_W'(i);
  end

  assign w_norm = w_abs << (K_W'(DWIDTH - 1) - o_k);
  // Top t bits of the normalised value; short operands get zeros shifted in.
  assign w_frac = w_norm >> (DWIDTH - int'(i_t));
  assign w_mask = (DWIDTH'(1) << (int'(i_t) - 1)) - DWIDTH'(1);
  assign o_x    = T_MAX'(((w_frac & w_mask) << 1) | DWIDTH'(1));
  assign o_zero = (i_v == '0);
endmodule

// File: rtl/dr_alm_pipe.sv
// Three-stage elastic DR-ALM: truncate | add | antilog+sign, valid/ready at both ends.
module dr_alm_pipe
  import dr_alm_pkg::*;
#(
  parameter int DWIDTH = DR_DWIDTH,
  parameter int T_MAX  = DR_T_MAX,
  parameter int TAG_W  = DR_TAG_W
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [DWIDTH-1:0]          i_a,
  input  logic [DWIDTH-1:0]          i_b,
  input  logic [$clog2(T_MAX+1)-1:0] i_t,
  input  logic [TAG_W-1:0]           i_tag,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [2*DWIDTH-1:0]        o_z,
  output logic [TAG_W-1:0]           o_tag
);
  logic                r_v1, r_v2, r_v3;
  s1_t                 r_s1;
  s2_t                 r_s2;
  logic [P_W-1:0]      r_z;
  logic [TAG_W-1:0]    r_tag;
  logic                w_adv1, w_adv2, w_adv3;
  logic [T_W-1:0]      w_t;
  logic [K_W-1:0]      w_ka, w_kb;
  logic [T_MAX-1:0]    w_xa, w_xb;
  logic                w_za, w_zb;
  s1_t                 w_s1;
  s2_t                 w_s2;
  logic                w_ovf;
  logic [T_MAX:0]      w_m;
  logic [K_W:0]        w_e;
  logic [P_W-1:0]      w_p, w_z;

  // A stage moves when it is empty or the next one takes its contents.
  assign w_adv3  = !r_v3 || i_ready;
  assign w_adv2  = !r_v2 || w_adv3;
  assign w_adv1  = !r_v1 || w_adv2;
  assign o_ready = w_adv1;
  assign o_valid = r_v3;
  assign o_z     = r_z;
  assign o_tag   = r_tag;

  assign w_t = clamp_t(i_t);

  dr_alm_trunc #(.DWIDTH(DWIDTH), .T_MAX(T_MAX)) u_trunc_a (
    .i_v(i_a), .i_t(w_t), .o_k(w_ka), .o_x(w_xa), .o_zero(w_za));
  dr_alm_trunc #(.DWIDTH(DWIDTH), .T_MAX(T_MAX)) u_trunc_b (
    .i_v(i_b), .i_t(w_t), .o_k(w_kb), .o_x(w_xb), .o_zero(w_zb));

  assign w_s1 = '{sign: i_a[DWIDTH-1] ^ i_b[DWIDTH-1], zero: w_za | w_zb,
                  ka: w_ka, kb: w_kb, xa: w_xa, xb: w_xb, t: w_t, tag: i_tag};

  assign w_s2 = '{sign: r_s1.sign, zero: r_s1.zero,
                  k: {1'b0, r_s1.ka} + {1'b0, r_s1.kb},
                  s: {1'b0, r_s1.xa} + {1'b0, r_s1.xb},
                  t: r_s1.t, tag: r_s1.tag};

  // S >= 2^t means the mantissa sum carried into the next binade.
  always_comb begin
    w_ovf = (r_s2.s >> r_s2.t) != '0;
    w_m   = w_ovf ? r_s2.s : r_s2.s + ((T_MAX+1)'(1) << r_s2.t);
    w_e   = r_s2.k + (K_W+1)'(w_ovf);
    if (int'(w_e) >= int'(r_s2.t))
      w_p = P_W'(w_m) << (int'(w_e) - int'(r_s2.t));
    else
      w_p = P_W'(w_m) >> (int'(r_s2.t) - int'(w_e));
    w_z = r_s2.zero ? '0 : (r_s2.sign ? -w_p : w_p);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_s1  <= '0;
      r_s2  <= '0;
      r_z   <= '0;
      r_tag <= '0;
    end else begin
      if (w_adv1) begin
        r_v1 <= i_valid;
        if (i_valid) r_s1 <= w_s1;
      end
      if (w_adv2) begin
        r_v2 <= r_v1;
        if (r_v1) r_s2 <= w_s2;
      end
      if (w_adv3) begin
        r_v3 <= r_v2;
        if (r_v2) begin
          r_z   <= w_z;
          r_tag <= r_s2.tag;
        end
      end
    end
  end
endmodule

// File: tb/tb_dr_alm_pipe.sv
// Vector table, handshake corner sequences and a randomized stream checked against
// an arithmetic model of the approximate product with a FIFO scoreboard.
module tb_dr_alm_pipe;
  logic        clk = 1'b0;
  logic        i_rst, i_valid, i_ready;
  logic [15:0] i_a, i_b;
  logic [3:0]  i_t, i_tag;
  logic        o_ready, o_valid;
  logic [31:0] o_z;
  logic [3:0]  o_tag;

  dr_alm_pipe dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_t(i_t), .i_tag(i_tag),
    .o_valid(o_valid), .i_ready(i_ready), .o_z(o_z), .o_tag(o_tag));

  always #5 clk = ~clk;

  typedef struct { longint z; logic [3:0] tag; } exp_t;
  typedef struct { int a; int b; int t; int tag; longint z; } vec_t;

  exp_t        q[$];
  longint      log_z[$];
  int          log_c[$];
  int          n_cmp = 0, n_bad = 0, n_out = 0, cyc_n = 0;
  bit          last_in, hold_chk;
  longint      last_z;
  logic [3:0]  last_tag;
  logic [31:0] hz;
  logic [3:0]  ht;

  task automatic chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Product from the arithmetic definition: mantissa fractions, log add, antilog.
  function automatic longint model(int a, int b, int tr);
    int t, ka, kb;
    longint ua, ub, xa, xb, s, m, e, p;
    t = (tr < 2) ? 2 : (tr > 8) ? 8 : tr;
    if (a == 0 || b == 0) return 0;
    ua = (a < 0) ? -a : a;
    ub = (b < 0) ? -b : b;
    ka = 0; kb = 0;
    while ((longint'(1) << (ka + 1)) <= ua) ka++;
    while ((longint'(1) << (kb + 1)) <= ub) kb++;
    xa = (((ua << (t - 1)) >> ka) % (longint'(1) << (t - 1))) * 2 + 1;
    xb = (((ub << (t - 1)) >> kb) % (longint'(1) << (t - 1))) * 2 + 1;
    s = xa + xb;
    if (s < (longint'(1) << t)) begin m = (longint'(1) << t) + s; e = ka + kb; end
    else begin m = s; e = ka + kb + 1; end
    p = (m << e) >> t;
    return ((a < 0) != (b < 0)) ? -p : p;
  endfunction

  task automatic drv(bit v, int a, int b, int t, int tag);
    i_valid = v;
    i_a = 16'(a);
    i_b = 16'(b);
    i_t = 4'(t);
    i_tag = 4'(tag);
  endtask

  // Sample just before the edge, score transfers, then step past the edge.
  task automatic cyc();
    bit inf, outf;
    exp_t e;
    #1;
    inf  = i_valid && o_ready && !i_rst;
    outf = o_valid && i_ready && !i_rst;
    if (hold_chk) begin
      chk("hold_valid", o_valid, 1);
      chk("hold_z", o_z, hz);
      chk("hold_tag", o_tag, ht);
    end
    hold_chk = o_valid && !i_ready && !i_rst;
    hz = o_z;
    ht = o_tag;
    if (outf) begin
      n_out++;
      last_z = longint'($signed(o_z));
      last_tag = o_tag;
      log_z.push_back(last_z);
      log_c.push_back(cyc_n);
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_unexpected: got output %0d want none", last_z);
      end else begin
        e = q.pop_front();
        chk("sb_z", last_z, e.z);
        chk("sb_tag", o_tag, e.tag);
      end
    end
    if (inf) begin
      e.z = model(int'($signed(i_a)), int'($signed(i_b)), int'(i_t));
      e.tag = i_tag;
      q.push_back(e);
    end
    if (i_rst) q.delete();
    last_in = inf;
    @(posedge clk);
    cyc_n++;
    #1;
  endtask

  function automatic int rnd_op();
    case ($urandom_range(0, 7))
      0: return 0;
      1: return -32768;
      2: return 32767;
      3: return int'($urandom_range(0, 20)) - 10;
      default: return int'($signed(16'($urandom)));
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    int   lat, n0, acc;
    logic [31:0] z0;

    vt.push_back('{3, 5, 6, 1, 14});
    vt.push_back('{-3, 5, 6, 2, -14});
    vt.push_back('{7, 7, 6, 3, 49});
    vt.push_back('{0, -9, 6, 4, 0});
    vt.push_back('{-32768, -32768, 6, 5, 1107296256});
    vt.push_back('{32767, 32767, 6, 6, 1056964608});
    vt.push_back('{3, 5, 3, 7, 16});
    vt.push_back('{3, 5, 15, 8, 14});
    vt.push_back('{3, 5, 0, 9, 16});
    vt.push_back('{-1, -1, 6, 10, 1});

    hold_chk = 0;
    i_rst = 1; i_ready = 1;
    drv(0, 0, 0, 6, 0);
    @(posedge clk); #1;
    cyc(); cyc();
    i_rst = 0;
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_z", o_z, 0);
    chk("rst_tag", o_tag, 0);

    foreach (vt[i]) begin
      i_ready = 1;
      drv(1, vt[i].a, vt[i].b, vt[i].t, vt[i].tag);
      n0 = n_out;
      cyc();
      chk("tbl_accept", last_in, 1);
      drv(0, 0, 0, 6, 0);
      lat = 0;
      while (n_out == n0 && lat < 10) begin lat++; cyc(); end
      chk("tbl_latency", lat, 3);
      chk("tbl_z", last_z, vt[i].z);
      chk("tbl_tag", last_tag, vt[i].tag);
    end

    // Back-to-back t change: t=3 then t=6 on the same operands.
    log_z.delete(); log_c.delete();
    i_ready = 1;
    drv(1, 3, 5, 3, 11); cyc();
    drv(1, 3, 5, 6, 12); cyc();
    drv(0, 0, 0, 6, 0);
    for (int c = 0; c < 10 && log_z.size() < 2; c++) cyc();
    if (log_z.size() < 2) begin
      n_cmp++; n_bad++;
      $display("FAIL b2b_count: got %0d want 2", log_z.size());
    end else begin
      chk("b2b_z1", log_z[0], 16);
      chk("b2b_z2", log_z[1], 14);
      chk("b2b_gap", log_c[1] - log_c[0], 1);
    end

    // Backpressure: 5 transactions against a stalled sink.
    i_ready = 0; acc = 0; n0 = n_out;
    for (int c = 0; c < 10 && acc < 3; c++) begin
      drv(1, acc * 1234 - 3000, 500 - acc * 77, 6, acc + 1);
      cyc();
      if (last_in) acc++;
    end
    chk("bp_accepts", acc, 3);
    chk("bp_ready_low", o_ready, 0);
    chk("bp_valid", o_valid, 1);
    z0 = o_z;
    drv(1, acc * 1234 - 3000, 500 - acc * 77, 6, acc + 1);
    for (int c = 0; c < 4; c++) cyc();
    chk("bp_z_stable", o_z, z0);
    chk("bp_no_accept", last_in, 0);
    i_ready = 1;
    for (int c = 0; c < 10 && acc < 5; c++) begin
      drv(1, acc * 1234 - 3000, 500 - acc * 77, 6, acc + 1);
      cyc();
      if (last_in) acc++;
    end
    drv(0, 0, 0, 6, 0);
    for (int c = 0; c < 20 && n_out - n0 < 5; c++) cyc();
    for (int c = 0; c < 3; c++) cyc();
    chk("bp_count", n_out - n0, 5);
    chk("bp_q_empty", q.size(), 0);

    // Reset with three in flight.
    i_ready = 0; acc = 0;
    for (int c = 0; c < 10 && acc < 3; c++) begin
      drv(1, 100 + acc, -7 - acc, 5, acc + 4);
      cyc();
      if (last_in) acc++;
    end
    chk("rf_accepts", acc, 3);
    drv(0, 0, 0, 6, 0);
    i_rst = 1;
    cyc();
    i_rst = 0;
    chk("rf_valid", o_valid, 0);
    chk("rf_z", o_z, 0);
    chk("rf_tag", o_tag, 0);
    chk("rf_ready", o_ready, 1);
    i_ready = 1; n0 = n_out;
    drv(1, 3, 5, 6, 13);
    cyc();
    chk("rf_accept_new", last_in, 1);
    drv(0, 0, 0, 6, 0);
    for (int c = 0; c < 8; c++) cyc();
    chk("rf_outs", n_out - n0, 1);
    chk("rf_new_z", last_z, 14);
    chk("rf_new_tag", last_tag, 13);

    // Randomized stream with random stalls and clamped t.
    n0 = n_out; acc = 0;
    for (int c = 0; c < 600; c++) begin
      i_ready = ($urandom_range(0, 3) != 0);
      drv($urandom_range(0, 3) != 0, rnd_op(), rnd_op(),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      cyc();
      if (last_in) acc++;
    end
    drv(0, 0, 0, 6, 0);
    i_ready = 1;
    for (int c = 0; c < 10; c++) cyc();
    chk("rand_count", n_out - n0, acc);
    chk("rand_q_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
